// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the RV32I pipeline hazard controller: forwarding selects,
// memory wait FSM states and the forwarding priority function.
package pipeline_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StWait  = 2'b01,
        StError = 2'b10
    } mem_state_e;

    // M-stage result is younger than W-stage result, so it wins.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       reg_write_m,
        input logic [4:0] rd_w,
        input logic       reg_write_w
    );
        if (reg_write_m && (rd_m != REG_X0) && (rd_m == rs)) begin
            return FWD_M;
        end else if (reg_write_w && (rd_w != REG_X0) && (rd_w == rs)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Wait-state tracker for the multi-cycle data memory: raises ms while an M-stage
// access is outstanding and latches a sticky mem_error when the access times out.
module mem_wait_fsm
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic mem_req_m,
    input  logic mem_ready,
    output logic ms,
    output logic mem_error
);

    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    mem_state_e        state_q;
    logic [WCNT_W-1:0] wcnt_q;

    // Mealy stall: the request cycle itself must already hold the pipeline.
    always_comb begin
        ms = 1'b0;
        if (state_q == StWait) begin
            ms = !mem_ready && (wcnt_q != WAIT_LAST);
        end else begin
            ms = mem_req_m && !mem_ready;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= StIdle;
            wcnt_q    <= '0;
            mem_error <= 1'b0;
        end else begin
            case (state_q)
                StWait: begin
                    if (mem_ready) begin
                        state_q <= StIdle;
                    end else if (wcnt_q == WAIT_LAST) begin
                        state_q   <= StError;
                        mem_error <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                default: begin
                    if (mem_req_m && !mem_ready) begin
                        state_q <= StWait;
                        wcnt_q  <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: forwarding,
// load-use stalls, branch flushes, memory wait stalls and performance counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic             load_e,
    input  logic             pc_src_e,
    input  logic [4:0]       rd_m,
    input  logic             reg_write_m,
    input  logic             mem_req_m,
    input  logic             mem_ready,
    input  logic [4:0]       rd_w,
    input  logic             reg_write_w,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    logic ms;
    logic lu;

    mem_wait_fsm #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_fsm (
        .Clk      (Clk),
        .Reset    (Reset),
        .mem_req_m(mem_req_m),
        .mem_ready(mem_ready),
        .ms       (ms),
        .mem_error(mem_error)
    );

    assign lu = load_e && (rd_e != REG_X0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    // A memory stall holds D and E, so branch/load-use flushes wait for ms to drop.
    always_comb begin
        forward_a_e = FWD_RF;
        forward_b_e = FWD_RF;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_w     = 1'b0;
        if (!Reset) begin
            forward_a_e = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
            forward_b_e = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
            stall_f     = ms | lu;
            stall_d     = ms | lu;
            stall_e     = ms;
            stall_m     = ms;
            flush_w     = ms;
            flush_e     = !ms & (lu | pc_src_e);
            flush_d     = !ms & pc_src_e;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            stall_cycles <= stall_cycles + CNT_W'(stall_f);
            flush_events <= flush_events + CNT_W'(flush_d);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: each cycle's expected outputs and
// counter values are queued when stimulus is driven and compared at the negedge.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned VW    = 12 + 2 * CNT_W;

    // vec bits: [11:10] fwd_a [9:8] fwd_b [7] sf [6] sd [5] se [4] sm [3] fd [2] fe [1] fw [0] merr
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rdm;
        logic       rwm;
        logic [4:0] rdw;
        logic       rww;
        logic [1:0] fa;
        logic [1:0] fb;
    } fwd_row_t;

    typedef struct packed {
        logic        rst;
        logic        req;
        logic        rdy;
        logic        pc;
        logic        lu;
        logic [11:0] vec;
    } ctl_row_t;

    logic Clk = 1'b0;
    logic Reset;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic load_e, pc_src_e, reg_write_m, mem_req_m, mem_ready, reg_write_w;
    logic [1:0] forward_a_e, forward_b_e;
    logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_error;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    logic [VW-1:0]    sb_q[$];
    logic [VW-1:0]    want;
    logic [VW-1:0]    obs;
    logic [CNT_W-1:0] exp_stall;
    logic [CNT_W-1:0] exp_flush;
    int checks = 0;
    int passes = 0;

    always #5 Clk = ~Clk;

    assign obs = {forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
                  flush_d, flush_e, flush_w, mem_error, stall_cycles, flush_events};

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(4),
        .CNT_W      (CNT_W)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .rs1_e       (rs1_e),
        .rs2_e       (rs2_e),
        .rd_e        (rd_e),
        .load_e      (load_e),
        .pc_src_e    (pc_src_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .mem_req_m   (mem_req_m),
        .mem_ready   (mem_ready),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .forward_a_e (forward_a_e),
        .forward_b_e (forward_b_e),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .stall_e     (stall_e),
        .stall_m     (stall_m),
        .flush_d     (flush_d),
        .flush_e     (flush_e),
        .flush_w     (flush_w),
        .mem_error   (mem_error),
        .stall_cycles(stall_cycles),
        .flush_events(flush_events)
    );

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr_inputs();
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
        load_e = 1'b0; pc_src_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
        mem_req_m = 1'b0; mem_ready = 1'b0;
    endtask

    // Queue this cycle's expectation; counters seen now reflect earlier cycles only.
    task automatic push_exp(input logic [11:0] v);
        sb_q.push_back({v, exp_stall, exp_flush});
        exp_stall = exp_stall + CNT_W'(v[7]);
        exp_flush = exp_flush + CNT_W'(v[3]);
    endtask

    task automatic drive_ctl(input ctl_row_t r);
        clr_inputs();
        Reset     = r.rst;
        mem_req_m = r.req;
        mem_ready = r.rdy;
        pc_src_e  = r.pc;
        if (r.lu) begin
            load_e = 1'b1; rd_e = 5'd7; rs1_d = 5'd7;
        end
    endtask

    task automatic test_reset();
        clr_inputs();
        Reset = 1'b1;
        rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1'b1;
        load_e = 1'b1; rd_e = 5'd3; rs1_d = 5'd3; pc_src_e = 1'b1; mem_req_m = 1'b1;
        next_cycle();
        exp_stall = '0;
        exp_flush = '0;
        push_exp(12'h000);
        @(negedge Clk);
        want = sb_q.pop_front();
        checks++;
        if (obs !== want) $display("FAIL reset: got %h want %h", obs, want);
        else passes++;
    endtask

    task automatic test_forwarding();
        fwd_row_t tab[6];
        tab = '{
            '{5'd5, 5'd0, 5'd5, 1'b1, 5'd5, 1'b1, 2'b10, 2'b00},
            '{5'd5, 5'd0, 5'd5, 1'b0, 5'd5, 1'b1, 2'b01, 2'b00},
            '{5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 2'b00, 2'b00},
            '{5'd3, 5'd9, 5'd3, 1'b1, 5'd9, 1'b1, 2'b10, 2'b01},
            '{5'd9, 5'd9, 5'd9, 1'b1, 5'd9, 1'b0, 2'b10, 2'b10},
            '{5'd4, 5'd6, 5'd6, 1'b0, 5'd4, 1'b1, 2'b01, 2'b00}
        };
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            clr_inputs();
            Reset = 1'b0;
            rs1_e = tab[i].rs1; rs2_e = tab[i].rs2;
            rd_m = tab[i].rdm; reg_write_m = tab[i].rwm;
            rd_w = tab[i].rdw; reg_write_w = tab[i].rww;
            push_exp({tab[i].fa, tab[i].fb, 8'h00});
            @(negedge Clk);
            want = sb_q.pop_front();
            checks++;
            if (obs !== want) $display("FAIL forwarding row %0d: got %h want %h", i, obs, want);
            else passes++;
        end
    endtask

    task automatic test_load_use();
        logic [4:0]  rde[5];
        logic [4:0]  r1[5];
        logic [4:0]  r2[5];
        logic        ld[5];
        logic [11:0] v[5];
        ld  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        rde = '{5'd7, 5'd7, 5'd0, 5'd7, 5'd7};
        r1  = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd7};
        r2  = '{5'd7, 5'd7, 5'd0, 5'd0, 5'd0};
        v   = '{12'h0C4, 12'h000, 12'h000, 12'h0C4, 12'h000};
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            clr_inputs();
            load_e = ld[i]; rd_e = rde[i]; rs1_d = r1[i]; rs2_d = r2[i];
            push_exp(v[i]);
            @(negedge Clk);
            want = sb_q.pop_front();
            checks++;
            if (obs !== want) $display("FAIL load_use step %0d: got %h want %h", i, obs, want);
            else passes++;
        end
    endtask

    task automatic test_ctl_seq(input string name, input ctl_row_t rows[$]);
        for (int i = 0; i < rows.size(); i++) begin
            next_cycle();
            drive_ctl(rows[i]);
            push_exp(rows[i].vec);
            if (rows[i].rst) begin
                exp_stall = '0;
                exp_flush = '0;
            end
            @(negedge Clk);
            want = sb_q.pop_front();
            checks++;
            if (obs !== want) $display("FAIL %s step %0d: got %h want %h", name, i, obs, want);
            else passes++;
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i <= 256; i++) begin
            next_cycle();
            clr_inputs();
            if (i < 256) begin
                load_e = 1'b1; rd_e = 5'd12; rs2_d = 5'd12;
            end
            push_exp(i < 256 ? 12'h0C4 : 12'h000);
            @(negedge Clk);
            want = sb_q.pop_front();
            checks++;
            if (obs !== want) $display("FAIL counter_wrap cycle %0d: got %h want %h", i, obs, want);
            else passes++;
        end
    endtask

    initial begin
        ctl_row_t seq[$];
        test_reset();
        test_forwarding();
        test_load_use();
        // rst req rdy pc lu vec
        seq = '{'{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h00C},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000}};
        test_ctl_seq("branch", seq);
        seq = '{'{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h0F2},
                '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h0F2},
                '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h0F2},
                '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h00C},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000},
                '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000}};
        test_ctl_seq("mem_wait", seq);
        seq = '{'{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0CC},
                '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h00C},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0C4},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000}};
        test_ctl_seq("back_to_back", seq);
        test_wrap();
        seq = '{'{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0F2},
                '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0F2},
                '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0F2},
                '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0F2},
                '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h001},
                '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0F3},
                '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h00D},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h001}};
        test_ctl_seq("timeout", seq);
        seq = '{'{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0F3},
                '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 12'h001},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000},
                '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0F2},
                '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h00C},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000}};
        test_ctl_seq("reset_mid_wait", seq);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RV32I pipeline (F/D/E/M/W).
- Generates E-stage forwarding selects, load-use stalls and branch flushes.
- Runs a wait-state FSM for a multi-cycle data memory.
- Drives hold/flush enables for the pipeline registers, including the M→W register, and keeps stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 16: max WAIT cycles before declaring a memory error (≥2).
- CNT_W, 32: width of the performance counters.

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- rs1_d, rs2_d  in  5  source regs in D
- rs1_e, rs2_e, rd_e  in  5  source/dest regs in E
- load_e  in  1  E-stage instruction is a load
- pc_src_e  in  1  taken branch/jump resolved in E
- rd_m  in  5  dest reg in M
- reg_write_m  in  1  M-stage instruction writes rd
- mem_req_m  in  1  M-stage load/store active
- mem_ready  in  1  data memory completes the access this cycle
- rd_w  in  5  dest reg in W
- reg_write_w  in  1  W-stage instruction writes rd
- forward_a_e, forward_b_e  out  2  00 = regfile, 10 = ALU result from M, 01 = result from W
- stall_f, stall_d, stall_e, stall_m  out  1  hold the corresponding register/PC
- flush_d, flush_e, flush_w  out  1  load a bubble into D/E/W registers
- mem_error  out  1  sticky memory timeout flag
- stall_cycles, flush_events  out  CNT_W  performance counters

Behaviour:
- Reset: synchronous and active-high.
  - FSM goes to IDLE; wait counter, mem_error and both performance counters clear to 0.
  - While Reset is high, all stall/flush/forward outputs are forced to 0.
- Forwarding (combinational, zero latency):
  - forward_a_e = 10 if reg_write_m && rd_m≠0 && rd_m==rs1_e.
  - Otherwise 01 if reg_write_w && rd_w≠0 && rd_w==rs1_e.
  - Otherwise 00. M has priority over W.
  - forward_b_e is identical using rs2_e.
- Load-use: lu = load_e && rd_e≠0 && (rd_e==rs1_d || rd_e==rs2_d). Stalls F and D and flushes E for exactly one cycle per occurrence.
- Branch: pc_src_e asserts flush_d and flush_e.
- Memory FSM (states IDLE, WAIT, ERROR):
  - IDLE: if mem_req_m && !mem_ready, assert ms (mem stall) this cycle and go to WAIT with wcnt=0. If mem_ready is high in the same cycle as the request, there is no stall.
  - WAIT: ms=1 while !mem_ready; wcnt increments each cycle.
    - mem_ready=1: ms=0 that cycle (M→W captures the data); go to IDLE.
    - wcnt==MEM_TIMEOUT-1 and !mem_ready: ms=0; go to ERROR; set mem_error.
  - ERROR: ms=0 and the pipeline runs. mem_error stays 1 until Reset. A new request is handled as in IDLE, but mem_error is never cleared.
- Output equations (ms has priority):
  - stall_f = stall_d = ms | lu
  - stall_e = stall_m = ms
  - flush_w = ms (bubble into W while M is held)
  - flush_e = !ms & (lu | pc_src_e)
  - flush_d = !ms & pc_src_e
- Priority cases:
  - A branch or load-use during ms is deferred: E and D are held, so the condition re-presents after ms drops.
  - Branch and load-use in the same cycle: flush_d=flush_e=1 and stall_f=stall_d=1. The branch wins; the F stall only repeats the redirected fetch.
- Counters:
  - stall_cycles increments every cycle stall_f=1.
  - flush_events increments every cycle flush_d=1.
  - Both wrap modulo 2^CNT_W.
- Reset asserted mid-WAIT aborts the wait: outputs go to 0 in the same cycle and the FSM is in IDLE at the next edge.

Decomposition:
- Shared package holds:
  - forwarding select constants FWD_RF=00, FWD_W=01, FWD_M=10
  - FSM state encoding
  - REG_X0=5'd0
- One sub-module, mem_wait_fsm, takes Clk, Reset, mem_req_m and mem_ready and produces ms and mem_error, with MEM_TIMEOUT as a parameter.
- Forwarding, load-use detection, output equations and counters stay in the top module.

Test Plan:
- Forwarding:
  - rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1, rs1_e=5 → forward_a_e=10.
  - Drop reg_write_m → forward_a_e=01.
  - rd_m=rd_w=0, rs1_e=0 → forward_a_e=00.
- Load-use: load_e=1, rd_e=7, rs2_d=7 for one cycle → stall_f=stall_d=flush_e=1 for that cycle only; stall_cycles 0→1.
- Branch: pc_src_e=1 → flush_d=flush_e=1; flush_events=1; stall_* all 0.
- Memory wait: mem_req_m=1, mem_ready=0 for 3 cycles, then 1.
  - Expect stall_f/d/e/m=1 and flush_w=1 for 3 cycles, then 0 on the ready cycle.
  - A pc_src_e=1 during the wait gives flush_d=0 until ready.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 → ms for 4 cycles; mem_error=1 from the next edge and stays 1 through further requests until Reset.
- Reset mid-WAIT: assert Reset during the 2nd wait cycle → all outputs 0 that cycle; counters and mem_error are 0 after the edge.
